// File: rtl/snake_body_engine.sv
// snake_body_engine
// Registered snake body for a grid game. Holds the segment list as a shift
// array, advances it one cell per effective step and handles growth, wall and
// self collisions, reversal rejection, pause and a saturating score. The
// pixel renderer asks about one grid cell at a time through query_x/query_y
// and gets head/body back combinationally.
//
// Ports
//   system_clk         clock, all state on the rising edge
//   reset              synchronous, active high, overrides everything
//   step               one-cycle move strobe
//   pause              level, freezes motion (grow still latches)
//   direction[1:0]     0=UP(y-1) 1=DOWN(y+1) 2=LEFT(x-1) 3=RIGHT(x+1)
//   grow               one-cycle apple-eaten pulse
//   query_x/query_y    cell being rendered
//   head/body          query cell is the head / an active body segment
//   head_x/head_y      current head position
//   length             active segment count
//   score              apples eaten, saturating
//   game_over          sticky collision flag
module snake_body_engine #(
    parameter int GRID_W      = 16,
    parameter int GRID_H      = 16,
    parameter int COORD_W     = 4,
    parameter int MAX_LENGTH  = 30,
    parameter int INIT_LENGTH = 3,
    parameter int START_X     = 4,
    parameter int START_Y     = 4,
    parameter int WRAP_MODE   = 0,
    parameter int SCORE_W     = 8
) (
    input  logic                               system_clk,
    input  logic                               reset,
    input  logic                               step,
    input  logic                               pause,
    input  logic [1:0]                         direction,
    input  logic                               grow,
    input  logic [COORD_W-1:0]                 query_x,
    input  logic [COORD_W-1:0]                 query_y,
    output logic                               head,
    output logic                               body,
    output logic [COORD_W-1:0]                 head_x,
    output logic [COORD_W-1:0]                 head_y,
    output logic [$clog2(MAX_LENGTH+1)-1:0]    length,
    output logic [SCORE_W-1:0]                 score,
    output logic                               game_over
);

    localparam int LEN_W = $clog2(MAX_LENGTH + 1);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [COORD_W-1:0] C_ONE  = COORD_W'(1);
    localparam logic [COORD_W-1:0] C_XMAX = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] C_YMAX = COORD_W'(GRID_H - 1);
    localparam logic [LEN_W-1:0]   L_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0]   L_MAX  = LEN_W'(MAX_LENGTH);

    // Segment 0 is the head; entries at index >= r_length are stale.
    logic [MAX_LENGTH-1:0][COORD_W-1:0] r_seg_x;
    logic [MAX_LENGTH-1:0][COORD_W-1:0] r_seg_y;
    logic [LEN_W-1:0]                   r_length;
    logic [SCORE_W-1:0]                 r_score;
    logic                               r_game_over;
    logic [1:0]                         r_heading;
    logic                               r_grow_pending;

    logic               w_step_eff;
    logic [1:0]         w_heading_nxt;
    logic [COORD_W-1:0] w_next_x;
    logic [COORD_W-1:0] w_next_y;
    logic               w_edge;
    logic               w_wall_hit;
    logic               w_grow_eff;
    logic [LEN_W-1:0]   w_cmp_len;
    logic               w_self_hit;
    logic               w_body_hit;

    assign w_step_eff = step & ~pause & ~r_game_over;

    // Opposite headings differ only in bit 0 (UP/DOWN, LEFT/RIGHT).
    always_comb begin
        w_heading_nxt = r_heading;
        if (direction != {r_heading[1], ~r_heading[0]})
            w_heading_nxt = direction;
    end

    // Next head: w_edge flags a move off the grid; the wrapped coordinate is
    // produced regardless and only used when wrapping is enabled.
    always_comb begin
        w_next_x = r_seg_x[0];
        w_next_y = r_seg_y[0];
        w_edge   = 1'b0;
        case (w_heading_nxt)
            DIR_UP: begin
                if (r_seg_y[0] == '0) begin
                    w_edge   = 1'b1;
                    w_next_y = C_YMAX;
                end else begin
                    w_next_y = r_seg_y[0] - C_ONE;
                end
            end
            DIR_DOWN: begin
                if (r_seg_y[0] == C_YMAX) begin
                    w_edge   = 1'b1;
                    w_next_y = '0;
                end else begin
                    w_next_y = r_seg_y[0] + C_ONE;
                end
            end
            DIR_LEFT: begin
                if (r_seg_x[0] == '0) begin
                    w_edge   = 1'b1;
                    w_next_x = C_XMAX;
                end else begin
                    w_next_x = r_seg_x[0] - C_ONE;
                end
            end
            default: begin
                if (r_seg_x[0] == C_XMAX) begin
                    w_edge   = 1'b1;
                    w_next_x = '0;
                end else begin
                    w_next_x = r_seg_x[0] + C_ONE;
                end
            end
        endcase
    end

    assign w_wall_hit = w_edge && (WRAP_MODE == 0);

    // The tail only stays put when the snake actually lengthens; at full
    // length it still vacates, so it is excluded from the collision check.
    assign w_grow_eff = (r_grow_pending | grow) && (r_length < L_MAX);
    assign w_cmp_len  = w_grow_eff ? r_length : (r_length - L_ONE);

    always_comb begin
        w_self_hit = 1'b0;
        for (int i = 0; i < MAX_LENGTH; i++) begin
            if (LEN_W'(i) < w_cmp_len && r_seg_x[i] == w_next_x && r_seg_y[i] == w_next_y)
                w_self_hit = 1'b1;
        end
    end

    always_comb begin
        w_body_hit = 1'b0;
        for (int i = 1; i < MAX_LENGTH; i++) begin
            if (LEN_W'(i) < r_length && r_seg_x[i] == query_x && r_seg_y[i] == query_y)
                w_body_hit = 1'b1;
        end
    end

    always_ff @(posedge system_clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_LENGTH; i++) begin
                if (i < INIT_LENGTH) begin
                    r_seg_x[i] <= COORD_W'(START_X - i);
                    r_seg_y[i] <= COORD_W'(START_Y);
                end else begin
                    r_seg_x[i] <= '0;
                    r_seg_y[i] <= '0;
                end
            end
            r_length       <= LEN_W'(INIT_LENGTH);
            r_score        <= '0;
            r_game_over    <= 1'b0;
            r_heading      <= DIR_RIGHT;
            r_grow_pending <= 1'b0;
        end else begin
            if (grow && !r_game_over) begin
                r_grow_pending <= 1'b1;
                if (r_score != {SCORE_W{1'b1}})
                    r_score <= r_score + SCORE_W'(1);
            end
            if (w_step_eff) begin
                r_heading <= w_heading_nxt;
                if (w_wall_hit || w_self_hit) begin
                    r_game_over <= 1'b1;
                end else begin
                    for (int i = MAX_LENGTH - 1; i > 0; i--) begin
                        r_seg_x[i] <= r_seg_x[i-1];
                        r_seg_y[i] <= r_seg_y[i-1];
                    end
                    r_seg_x[0]     <= w_next_x;
                    r_seg_y[0]     <= w_next_y;
                    r_length       <= r_length + LEN_W'(w_grow_eff);
                    // Overrides a same-cycle grow: this move consumes it.
                    r_grow_pending <= 1'b0;
                end
            end
        end
    end

    assign head      = (query_x == r_seg_x[0]) && (query_y == r_seg_y[0]);
    assign body      = w_body_hit;
    assign head_x    = r_seg_x[0];
    assign head_y    = r_seg_y[0];
    assign length    = r_length;
    assign score     = r_score;
    assign game_over = r_game_over;

endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: two instances (wall mode and wrap mode) share
// one stimulus stream. Each cycle the stimulus task advances a list-based
// reference model and queues the expected outputs; a monitor pops and
// compares after every rising edge.
module tb_snake_body_engine;
    localparam int GW = 16;
    localparam int GH = 16;
    localparam int ML = 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, stp = 1'b0, pse = 1'b0, grw = 1'b0;
    logic [1:0] dir = 2'd3;
    logic [3:0] qx = '0, qy = '0;

    logic       hd0, bd0, go0, hd1, bd1, go1;
    logic [3:0] hx0, hy0, hx1, hy1;
    logic [4:0] ln0, ln1;
    logic [7:0] sc0, sc1;

    snake_body_engine #(.WRAP_MODE(0)) d0 (
        .system_clk(clk), .reset(rst), .step(stp), .pause(pse), .direction(dir), .grow(grw),
        .query_x(qx), .query_y(qy), .head(hd0), .body(bd0), .head_x(hx0), .head_y(hy0),
        .length(ln0), .score(sc0), .game_over(go0));

    snake_body_engine #(.WRAP_MODE(1)) d1 (
        .system_clk(clk), .reset(rst), .step(stp), .pause(pse), .direction(dir), .grow(grw),
        .query_x(qx), .query_y(qy), .head(hd1), .body(bd1), .head_x(hx1), .head_y(hy1),
        .length(ln1), .score(sc1), .game_over(go1));

    typedef struct { int hx; int hy; int len; int sc; int go; int hd; int bd; } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    int nvec = 0;
    int nbad = 0;

    // Reference model: cell list per instance, index 0 = head.
    int mx[2][64];
    int my[2][64];
    int mlen[2], mhd[2], mpend[2], msc[2], mover[2];

    task automatic model_step(input int w, input bit r, input bit s, input bit p,
                              input int d, input bit g);
        int nx, ny, lim;
        bit out, hit, grows, was_over;
        if (r) begin
            for (int i = 0; i < 64; i++) begin
                mx[w][i] = 0;
                my[w][i] = 0;
            end
            for (int i = 0; i < 3; i++) begin
                mx[w][i] = 4 - i;
                my[w][i] = 4;
            end
            mlen[w] = 3; msc[w] = 0; mover[w] = 0; mhd[w] = 3; mpend[w] = 0;
        end else begin
            was_over = mover[w] != 0;
            if (g && !was_over) begin
                mpend[w] = 1;
                if (msc[w] < 255) msc[w]++;
            end
            if (s && !p && !was_over) begin
                if (d != (mhd[w] ^ 1)) mhd[w] = d;
                nx = mx[w][0];
                ny = my[w][0];
                case (mhd[w])
                    0: ny = ny - 1;
                    1: ny = ny + 1;
                    2: nx = nx - 1;
                    default: nx = nx + 1;
                endcase
                out = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
                if (w == 1) begin
                    nx = (nx + GW) % GW;
                    ny = (ny + GH) % GH;
                    out = 0;
                end
                grows = (mpend[w] != 0) && (mlen[w] < ML);
                lim = grows ? mlen[w] : mlen[w] - 1;
                hit = 0;
                for (int i = 0; i < lim; i++)
                    if (mx[w][i] == nx && my[w][i] == ny) hit = 1;
                if (out || hit) begin
                    mover[w] = 1;
                end else begin
                    for (int i = mlen[w]; i > 0; i--) begin
                        mx[w][i] = mx[w][i-1];
                        my[w][i] = my[w][i-1];
                    end
                    mx[w][0] = nx;
                    my[w][0] = ny;
                    if (grows) mlen[w]++;
                    mpend[w] = 0;
                end
            end
        end
    endtask

    function automatic exp_t mk(input int w);
        exp_t e;
        e.hx  = mx[w][0];
        e.hy  = my[w][0];
        e.len = mlen[w];
        e.sc  = msc[w];
        e.go  = mover[w];
        e.hd  = (mx[w][0] == int'(qx) && my[w][0] == int'(qy)) ? 1 : 0;
        e.bd  = 0;
        for (int i = 1; i < mlen[w]; i++)
            if (mx[w][i] == int'(qx) && my[w][i] == int'(qy)) e.bd = 1;
        return e;
    endfunction

    // One clock of stimulus. fx < 0 picks a query biased toward snake cells
    // (including stale ones just past the tail).
    task automatic cyc(input bit r, input bit s, input bit p, input int d, input bit g,
                       input int fx = -1, input int fy = -1);
        int k, w;
        @(negedge clk);
        rst = r; stp = s; pse = p; dir = 2'(d); grw = g;
        model_step(0, r, s, p, d, g);
        model_step(1, r, s, p, d, g);
        if (fx >= 0) begin
            qx = 4'(fx);
            qy = 4'(fy);
        end else if ($urandom_range(0, 3) == 0) begin
            qx = 4'($urandom_range(0, GW - 1));
            qy = 4'($urandom_range(0, GH - 1));
        end else begin
            w = int'($urandom_range(0, 1));
            k = int'($urandom_range(0, mlen[w]));
            qx = 4'(mx[w][k]);
            qy = 4'(my[w][k]);
        end
        q0.push_back(mk(0));
        q1.push_back(mk(1));
    endtask

    task automatic check(input int w, input exp_t e, input exp_t g);
        nvec++;
        if (e.hx != g.hx || e.hy != g.hy || e.len != g.len || e.sc != g.sc ||
            e.go != g.go || e.hd != g.hd || e.bd != g.bd) begin
            nbad++;
            $display("FAIL wrap%0d state @%0t q=(%0d,%0d): got hx=%0d hy=%0d len=%0d score=%0d go=%0d head=%0d body=%0d; want hx=%0d hy=%0d len=%0d score=%0d go=%0d head=%0d body=%0d",
                     w, $time, qx, qy, g.hx, g.hy, g.len, g.sc, g.go, g.hd, g.bd,
                     e.hx, e.hy, e.len, e.sc, e.go, e.hd, e.bd);
        end
    endtask

    initial begin : monitor
        exp_t e, g;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                g.hx = int'(hx0); g.hy = int'(hy0); g.len = int'(ln0); g.sc = int'(sc0);
                g.go = int'(go0); g.hd = int'(hd0); g.bd = int'(bd0);
                check(0, e, g);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                g.hx = int'(hx1); g.hy = int'(hy1); g.len = int'(ln1); g.sc = int'(sc1);
                g.go = int'(go1); g.hd = int'(hd1); g.bd = int'(bd1);
                check(1, e, g);
            end
        end
    end

    initial begin : stim
        // Reset state and initial body cells.
        cyc(1, 0, 0, 3, 0);
        cyc(0, 0, 0, 3, 0, 4, 4);
        cyc(0, 0, 0, 3, 0, 3, 4);
        cyc(0, 0, 0, 3, 0, 2, 4);
        cyc(0, 0, 0, 3, 0, 1, 4);
        // Three steps right; old head cell (4,4) must be empty.
        repeat (3) cyc(0, 1, 0, 3, 0);
        cyc(0, 0, 0, 3, 0, 4, 4);
        cyc(0, 0, 0, 3, 0, 5, 4);
        // Grow then step, grow with step, grow during pause.
        cyc(0, 0, 0, 3, 1);
        cyc(0, 1, 0, 3, 0);
        cyc(0, 1, 0, 3, 1);
        cyc(0, 0, 1, 3, 1);
        cyc(0, 1, 1, 3, 0);
        cyc(0, 0, 0, 3, 0);
        cyc(0, 1, 0, 3, 0);
        // Reversal rejected, then pause holds through steps.
        cyc(0, 1, 0, 2, 0);
        repeat (5) cyc(0, 1, 1, 3, 0);
        // Run into the right edge: wall in one instance, wrap in the other.
        repeat (8) cyc(0, 1, 0, 3, 0);
        cyc(0, 0, 0, 3, 1);
        // Reset during game over, coincident with step and grow.
        cyc(1, 1, 0, 3, 1);
        cyc(0, 0, 0, 3, 0);
        // Length 5 then DOWN, LEFT, UP into the body.
        cyc(0, 1, 0, 3, 1);
        cyc(0, 1, 0, 3, 1);
        cyc(0, 1, 0, 1, 0);
        cyc(0, 1, 0, 2, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        // Length 4 chasing its own tail cell is legal.
        cyc(1, 0, 0, 3, 0);
        cyc(0, 1, 0, 3, 1);
        cyc(0, 1, 0, 1, 0);
        cyc(0, 1, 0, 2, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 4, 4);
        // Serpentine growth to full length, then keep growing.
        cyc(1, 0, 0, 3, 0);
        repeat (10) cyc(0, 1, 0, 3, 1);
        repeat (2)  cyc(0, 1, 0, 1, 1);
        repeat (13) cyc(0, 1, 0, 2, 1);
        repeat (5)  cyc(0, 1, 0, 1, 1);
        cyc(0, 0, 0, 1, 1);
        // Score saturation while paused.
        cyc(1, 0, 0, 3, 0);
        repeat (260) cyc(0, 0, 1, 3, 1);
        cyc(0, 1, 0, 3, 0);
        // Random traffic.
        repeat (2000)
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 9) == 0, int'($urandom_range(0, 3)),
                $urandom_range(0, 5) == 0);
        cyc(0, 0, 0, 3, 0);
        repeat (3) @(posedge clk);
        #2;
        nvec++;
        if (q0.size() != 0 || q1.size() != 0) begin
            nbad++;
            $display("FAIL drain: %0d/%0d expectations left, want 0/0", q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule

// File: doc/snake_body_engine.md
Name: snake_body_engine

Overview:
- Parametrised successor to the team's snake body/collision wrapper.
- Holds the snake as a registered segment shift array and advances it one cell per `step` strobe, with grid size, maximum length and edge mode set by parameters.
- Adds behaviour the earlier block lacks: in-block growth with a pending-grow latch, wall/self-collision detection with a sticky game-over, reversal rejection, pause, and a saturating score.
- Sits between the game FSM and the pixel renderer; answers per-pixel head/body queries combinationally.

Parameters:
- GRID_W, 16, grid columns; x is legal in 0..GRID_W-1.
- GRID_H, 16, grid rows; y is legal in 0..GRID_H-1.
- COORD_W, 4, coordinate width; must satisfy 2^COORD_W >= max(GRID_W, GRID_H).
- MAX_LENGTH, 30, segment capacity including the head.
- INIT_LENGTH, 3, length after reset; 1 <= INIT_LENGTH <= MAX_LENGTH.
- START_X, 4, head x after reset; requires START_X >= INIT_LENGTH-1.
- START_Y, 4, head y after reset.
- WRAP_MODE, 0, edge behaviour: 0 = wall ends the game, 1 = wrap to the opposite edge.
- SCORE_W, 8, score width.

Ports:
- system_clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- step, input, 1, one-cycle move strobe.
- pause, input, 1, level; holds all motion state while high.
- direction, input, 2, requested heading: 0=UP(y-1), 1=DOWN(y+1), 2=LEFT(x-1), 3=RIGHT(x+1).
- grow, input, 1, one-cycle good-collision (apple eaten) pulse.
- query_x, input, COORD_W, pixel x being rendered.
- query_y, input, COORD_W, pixel y being rendered.
- head, output, 1, query pixel equals head position.
- body, output, 1, query pixel equals an active segment 1..length-1.
- head_x, output, COORD_W, current head x.
- head_y, output, COORD_W, current head y.
- length, output, $clog2(MAX_LENGTH+1), number of active segments.
- score, output, SCORE_W, apples eaten.
- game_over, output, 1, sticky collision flag.

Behaviour:
- All state updates on the rising edge of system_clk; reset is synchronous and active-high.
- Reset values:
  - segment i = (START_X-i, START_Y) for i < INIT_LENGTH; unused segments = 0.
  - length = INIT_LENGTH; score = 0; game_over = 0; heading = RIGHT; grow_pending = 0.
  - Reset asserted mid-operation overrides everything, including a simultaneous step or grow.
- grow handling:
  - grow sets grow_pending on any cycle it is high, including during pause or alongside step.
  - grow is ignored while game_over = 1.
  - score increments by 1 per grow pulse and saturates at 2^SCORE_W-1.
- Heading update, evaluated at each effective step (step & ~pause & ~game_over):
  - Heading takes direction unless direction is the exact reverse of the current heading; a reversal is ignored.
- Next-head computation:
  - WRAP_MODE=0: a move off the grid (x<0, x>=GRID_W, y<0, y>=GRID_H) sets game_over. The segment array does not move.
  - WRAP_MODE=1: coordinates wrap modulo GRID_W / GRID_H, e.g. x=GRID_W-1 moving RIGHT gives x=0.
- Self-collision:
  - The next head is compared against segments 0..length-2 when not growing this step; the tail cell is vacating, so moving into it is legal.
  - When growing this step, it is compared against segments 0..length-1.
  - A hit sets game_over; the array does not move.
- Legal move:
  - Segments shift: seg[i] <= seg[i-1]; seg[0] <= next head.
  - If grow_pending or grow was high this cycle and length < MAX_LENGTH: length += 1.
  - grow_pending clears on every legal move.
  - At length = MAX_LENGTH the snake moves without growing; score still counts.
- Latency:
  - head_x/head_y/length update one cycle after the step edge.
  - head/body are combinational from query_x/query_y and the registered state, valid in the same cycle.
- Activity gating:
  - game_over is sticky until reset; step is ignored while it is set.
  - pause=1 suppresses step entirely; pause and game_over do not change the query outputs.
- Segments at index >= length never assert body.

Test Plan:
- Reset with defaults -> head=(4,4); body asserted at (3,4) and (2,4); length=3, score=0, game_over=0.
- Three steps with direction=RIGHT -> head=(7,4), body at (6,4) and (5,4), nothing at (4,4).
- grow pulse then one step -> length=4, score=1; grow coincident with a step -> that step grows. A grow pulse during pause=1 -> applied on the first step after release.
- direction=LEFT while heading RIGHT, then step -> head moves RIGHT (reversal rejected). pause=1 plus 5 steps -> head unchanged.
- WRAP_MODE=0, drive head to x=15 heading RIGHT, then step -> game_over=1, head stays at 15, later steps ignored. WRAP_MODE=1, same stimulus -> head x=0, game_over=0.
- Grow to length 5, then steer DOWN, LEFT, UP into a body cell -> game_over=1. With length=4, moving the head into the current tail cell without grow -> legal, game_over=0.
- Grow to MAX_LENGTH=30 and pulse grow again -> length stays 30, score increments. Assert reset during game_over -> all reset values restored on the next edge.
